// File: rtl/trig_counter_pkg.sv
// trig_counter_pkg: trigger bit indices and auto-mode FSM encoding shared by the counter.
`default_nettype none

package trig_counter_pkg;

    localparam int TRIG_CLR  = 0;
    localparam int TRIG_UP   = 1;
    localparam int TRIG_DOWN = 2;
    localparam int TRIG_LOAD = 3;
    localparam int TRIG_SNAP = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..period while enabled and pulses tick on reaching period.
`default_nettype none

module tick_prescaler #(
    parameter int PRE_W = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] cnt;

    assign tick = en && (cnt == period);

    // Dropping en for a cycle is how the parent restarts the prescaler from 0.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRE_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/trig_counter.sv
// trig_counter: trigger-driven up/down counter with prescaled auto mode, limit pulses and snapshot.
`default_nettype none

module trig_counter
    import trig_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0,
    parameter int PRE_W    = 16
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic [4:0]       trig,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_en,
    input  logic             auto_dir,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic [15:0]      snap_lo,
    output logic [15:0]      snap_hi,
    output logic             tc_up,
    output logic             tc_down,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic             tick;
    logic             pre_en;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_up_nxt;
    logic             tc_down_nxt;
    logic             step_up;
    logic             step_down;

    wire do_clr  = trig[TRIG_CLR];
    wire do_load = trig[TRIG_LOAD];
    wire do_up   = trig[TRIG_UP];
    wire do_down = trig[TRIG_DOWN];
    wire do_snap = trig[TRIG_SNAP];

    // clr/load restart the prescaler by withholding enable for that cycle.
    assign pre_en = auto_en && !do_clr && !do_load;

    tick_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .sys_clk (sys_clk),
        .reset   (reset),
        .en      (pre_en),
        .period  (prescale),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (auto_en)  state_nxt = ST_RUN;
            ST_RUN:  if (!auto_en) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign running = (state == ST_RUN);

    // Any manual trigger, even the cancelling up+down pair, pre-empts the auto tick.
    always_comb begin
        count_nxt   = count;
        tc_up_nxt   = 1'b0;
        tc_down_nxt = 1'b0;
        step_up     = 1'b0;
        step_down   = 1'b0;
        if (do_clr) begin
            count_nxt = '0;
        end else if (do_load) begin
            count_nxt = load_value;
        end else if (do_up || do_down) begin
            step_up   = do_up && !do_down;
            step_down = do_down && !do_up;
        end else if (tick) begin
            step_up   = !auto_dir;
            step_down = auto_dir;
        end

        if (step_up) begin
            if (count == MAX_VAL) begin
                tc_up_nxt = 1'b1;
                count_nxt = (SATURATE != 0) ? MAX_VAL : '0;
            end else begin
                count_nxt = count + WIDTH'(1);
            end
        end else if (step_down) begin
            if (count == '0) begin
                tc_down_nxt = 1'b1;
                count_nxt   = (SATURATE != 0) ? '0 : MAX_VAL;
            end else begin
                count_nxt = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            tc_up   <= 1'b0;
            tc_down <= 1'b0;
            snap_lo <= '0;
            snap_hi <= '0;
        end else begin
            count   <= count_nxt;
            tc_up   <= tc_up_nxt;
            tc_down <= tc_down_nxt;
            if (do_snap) begin
                snap_lo <= count[15:0];
                snap_hi <= 16'(count[WIDTH-1:16]);
            end
        end
    end

endmodule

`default_nettype wire
